// File: rtl/issue_controller_pkg.sv
// Shared types and constants for the issue/stall controller slice.
//   issue_state_t  : controller state (RUN, MD_BUSY)
//   MD_LAT_DEFAULT : default mul/div latency, MD_START to MD_DONE
//   REG_IDX_W      : width of an architectural register index
package issue_controller_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } issue_state_t;

  localparam int MD_LAT_DEFAULT = 34;
  localparam int REG_IDX_W      = 5;

endpackage

// File: rtl/issue_controller_reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// Ports:
//   CLK, RSTN                 clock, async active-low reset
//   set_en, set_idx           mark a register pending (wins over a clear)
//   clr0_en, clr0_idx         clear port 0 (load writeback)
//   clr1_en, clr1_idx         clear port 1 (mul/div completion)
//   rdN_idx -> rdN_bit        three registered read ports (no bypass)
//   sb                        full pending vector
// Bit 0 (x0) is never pending.
module reg_scoreboard
  import issue_controller_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr0_en,
  input  logic [REG_IDX_W-1:0] clr0_idx,
  input  logic                 clr1_en,
  input  logic [REG_IDX_W-1:0] clr1_idx,
  input  logic [REG_IDX_W-1:0] rd0_idx,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic                 rd0_bit,
  output logic                 rd1_bit,
  output logic                 rd2_bit,
  output logic [NREG-1:0]      sb
);

  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)  set_vec[set_idx]  = 1'b1;
    if (clr0_en) clr_vec[clr0_idx] = 1'b1;
    if (clr1_en) clr_vec[clr1_idx] = 1'b1;
  end

  // Clear first, then OR the set back in so a same-cycle set survives.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sb <= '0;
    end else begin
      sb <= ((sb & ~clr_vec) | set_vec) & X0_MASK;
    end
  end

  assign rd0_bit = sb[rd0_idx];
  assign rd1_bit = sb[rd1_idx];
  assign rd2_bit = sb[rd2_idx];

endmodule

// File: rtl/issue_controller.sv
// Issue/stall controller between decode and execute of the RV32IM core.
// Tracks long-latency destinations (loads, mul/div) in a scoreboard, stalls
// decode on RAW/WAW hazards, sequences the single shared mul/div unit and
// inserts a one-cycle bubble after a redirect.
// Ports:
//   CLK, RSTN                      clock, async active-low reset
//   ID_VALID, ID_RS1/RS2/RD        decode slot contents
//   ID_IS_MD, ID_IS_LOAD           instruction class
//   WB_VALID, WB_RD                load writeback
//   FLUSH                          redirect; kills the decode slot
//   ID_READY, ISSUE                combinational handshake
//   MD_START, MD_DONE, MD_RD       registered mul/div sequencing
//   SB_OUT                         scoreboard pending bits
//   STALL_CNT                      saturating count of stalled cycles
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 ID_VALID,
  input  logic [REG_IDX_W-1:0] ID_RS1,
  input  logic [REG_IDX_W-1:0] ID_RS2,
  input  logic [REG_IDX_W-1:0] ID_RD,
  input  logic                 ID_IS_MD,
  input  logic                 ID_IS_LOAD,
  input  logic                 WB_VALID,
  input  logic [REG_IDX_W-1:0] WB_RD,
  input  logic                 FLUSH,
  output logic                 ID_READY,
  output logic                 ISSUE,
  output logic                 MD_START,
  output logic                 MD_DONE,
  output logic [REG_IDX_W-1:0] MD_RD,
  output logic [NREG-1:0]      SB_OUT,
  output logic [CNT_W-1:0]     STALL_CNT
);

  localparam int LAT_W = $clog2(MD_LAT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  issue_state_t         state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic                 md_start_q, md_start_d;
  logic                 md_done_q, md_done_d;
  logic [REG_IDX_W-1:0] md_rd_q, md_rd_d;
  logic                 bub_q;
  logic [CNT_W-1:0]     stall_cnt_q;

  logic rs1_pend, rs2_pend, rd_pend;
  logic hazard, struct_hz, id_ready, issue, sb_set;

  // Hazard detection reads the registered scoreboard only.
  assign hazard    = ((ID_RS1 != '0) & rs1_pend) |
                     ((ID_RS2 != '0) & rs2_pend) |
                     ((ID_RD  != '0) & rd_pend);
  assign struct_hz = ID_IS_MD & (state_q == MD_BUSY);
  assign id_ready  = ~FLUSH & ~bub_q & ~hazard & ~struct_hz;
  assign issue     = ID_VALID & id_ready;
  assign sb_set    = issue & (ID_IS_LOAD | ID_IS_MD) & (ID_RD != '0);

  reg_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .set_en   (sb_set),
    .set_idx  (ID_RD),
    .clr0_en  (WB_VALID),
    .clr0_idx (WB_RD),
    .clr1_en  (md_done_q),
    .clr1_idx (md_rd_q),
    .rd0_idx  (ID_RS1),
    .rd1_idx  (ID_RS2),
    .rd2_idx  (ID_RD),
    .rd0_bit  (rs1_pend),
    .rd1_bit  (rs2_pend),
    .rd2_bit  (rd_pend),
    .sb       (SB_OUT)
  );

  // Next-state: RUN accepts a mul/div; MD_BUSY counts down and returns to
  // RUN in the same edge that raises MD_DONE, so a waiting mul/div can
  // issue during the MD_DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_done_d  = 1'b0;
    md_rd_d    = md_rd_q;
    case (state_q)
      RUN: begin
        if (issue && ID_IS_MD) begin
          state_d    = MD_BUSY;
          md_start_d = 1'b1;
          md_rd_d    = ID_RD;
          cnt_d      = LAT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = RUN;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // State register boundary
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      md_start_q  <= 1'b0;
      md_done_q   <= 1'b0;
      md_rd_q     <= '0;
      bub_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_done_q  <= md_done_d;
      md_rd_q    <= md_rd_d;
      bub_q      <= FLUSH;
      if (ID_VALID && !id_ready) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign ID_READY  = id_ready;
  assign ISSUE     = issue;
  assign MD_START  = md_start_q;
  assign MD_DONE   = md_done_q;
  assign MD_RD     = md_rd_q;
  assign STALL_CNT = stall_cnt_q;

endmodule
